// File: rtl/addsub_defs.sv
// Shared definitions for the bit-serial adder-subtractor.
//   state_t  : FSM encoding (S_IDLE, S_RUN, S_DONE)
//   MODE_ADD : mode input value selecting A+B
//   MODE_SUB : mode input value selecting A-B
package addsub_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_add_bit.sv
// One-bit combinational full adder; the only arithmetic element of the
// serial datapath.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_serial.sv
// Bit-serial adder-subtractor. One result bit is produced per clock by a
// single full adder, LSB first. Subtraction is A + ~B + 1.
//   clk    : clock, rising edge
//   rst    : synchronous reset, active-high
//   start  : request, sampled when not busy (IDLE or DONE)
//   mode   : 0 add, 1 subtract; sampled with start
//   a, b   : operands; sampled with start
//   busy   : high while the serial operation runs
//   done   : one-cycle pulse when result/flags are updated
//   result : A+B or A-B modulo 2^WIDTH
//   cout   : carry out of MSB (subtract: 1 = no borrow)
//   ovf    : signed overflow (carry into MSB xor carry out of MSB)
//   zero   : result == 0
module addsub_serial
  import addsub_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] acc_reg;     // internal result shift register
  logic             carry_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  full_add_bit u_fa (
    .a    (opa_reg[0]),
    .b    (opb_reg[0]),
    .cin  (carry_reg),
    .s    (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB, so after WIDTH shifts the LSB-first
  // stream ends up in the right bit positions.
  assign acc_next = {fa_sum, acc_reg[WIDTH-1:1]};
  assign cnt_next = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      carry_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // DONE accepts a new request exactly like IDLE, allowing
        // back-to-back operations.
        S_IDLE, S_DONE: begin
          if (start) begin
            opa_reg   <= a;
            opb_reg   <= (mode == MODE_SUB) ? ~b : b;
            carry_reg <= (mode != MODE_ADD);
            cnt_reg   <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_RUN;
          end else begin
            state_reg <= S_IDLE;
          end
        end

        S_RUN: begin
          opa_reg   <= opa_reg >> 1;
          opb_reg   <= opb_reg >> 1;
          acc_reg   <= acc_next;
          carry_reg <= fa_cout;
          cnt_reg   <= cnt_next;
          if (cnt_reg == LAST_CNT) begin
            // carry_reg here is the carry into the MSB.
            result_reg <= acc_next;
            cout_reg   <= fa_cout;
            ovf_reg    <= carry_reg ^ fa_cout;
            zero_reg   <= (acc_next == '0);
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign cout   = cout_reg;
  assign ovf    = ovf_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial. Two instances (WIDTH=4 and
// WIDTH=8) share clock, reset, start and mode; the 4-bit one sees the low
// nibble of the operands. Expected values come from an arithmetic model.
module tb_addsub_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;

  logic       busy4, done4, cout4, ovf4, zero4;
  logic [3:0] res4;
  logic       busy8, done8, cout8, ovf8, zero8;
  logic [7:0] res8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] prev4 = '0;
  logic [7:0] prev8 = '0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a_in[3:0]), .b(b_in[3:0]),
    .busy(busy4), .done(done4), .result(res4),
    .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  addsub_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a_in), .b(b_in),
    .busy(busy8), .done(done8), .result(res8),
    .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as unsigned and
  // signed w-bit numbers.
  task automatic model(input int w, input logic m, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic c, output logic v, output logic z);
    int mask, ua, ub, sa, sb, s, ss;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    if (!m) begin
      s  = ua + ub;
      c  = (s >= (1 << w));
      ss = sa + sb;
    end else begin
      s  = ua - ub;
      c  = (ua >= ub);
      ss = sa - sb;
    end
    r = 8'(s & mask);
    v = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
    z = (r == 8'd0);
  endtask

  // One operation on both instances. inj (2..4) pulses start with junk
  // operands while both are busy; 0 means no extra pulse.
  task automatic run_op(input string name, input logic m, input logic [7:0] a,
                        input logic [7:0] b, input int inj);
    logic [7:0] r4, r8;
    logic c4, v4, z4, c8, v8, z8;
    model(4, m, a, b, r4, c4, v4, z4);
    model(8, m, a, b, r8, c8, v8, z8);
    $display("[TB] op %s mode=%0d a=%0h b=%0h exp4=%0h exp8=%0h inj=%0d",
             name, m, a, b, r4, r8, inj);
    @(negedge clk);
    start = 1'b1; mode = m; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); mode = 1'($urandom);
    @(negedge clk);
    chk({name, "_busy4_0"}, busy4, 1);
    chk({name, "_busy8_0"}, busy8, 1);
    chk({name, "_hold4_0"}, res4, prev4[3:0]);
    chk({name, "_hold8_0"}, res8, prev8);
    for (int i = 1; i <= 8; i++) begin
      if (i == inj) begin
        start = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom); mode = 1'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk({name, "_done4"}, done4, (i == 4));
      chk({name, "_done8"}, done8, (i == 8));
      chk({name, "_busy4"}, busy4, (i < 4));
      chk({name, "_busy8"}, busy8, (i < 8));
      if (i == 2) begin
        chk({name, "_hold4"}, res4, prev4[3:0]);
        chk({name, "_hold8"}, res8, prev8);
      end
      if (i == 4) begin
        chk({name, "_res4"},  res4,  r4[3:0]);
        chk({name, "_cout4"}, cout4, c4);
        chk({name, "_ovf4"},  ovf4,  v4);
        chk({name, "_zero4"}, zero4, z4);
      end
      if (i == 8) begin
        chk({name, "_res8"},  res8,  r8);
        chk({name, "_cout8"}, cout8, c8);
        chk({name, "_ovf8"},  ovf8,  v8);
        chk({name, "_zero8"}, zero8, z8);
        chk({name, "_res4_held"}, res4, r4[3:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk({name, "_done8_end"}, done8, 0);
    chk({name, "_busy8_end"}, busy8, 0);
    prev4 = r4;
    prev8 = r8;
  endtask

  initial begin
    logic [7:0] ra, rb, rc;
    logic c_a, v_a, z_a, c_b, v_b, z_b, c_c, v_c, z_c;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0);
    chk("rst_res4", res4, 0);   chk("rst_cout4", cout4, 0);
    chk("rst_ovf4", ovf4, 0);   chk("rst_zero4", zero4, 0);
    chk("rst_busy8", busy8, 0); chk("rst_res8", res8, 0);
    chk("rst_zero8", zero8, 0);
    rst = 1'b0;

    // Directed cases with literal expectations
    run_op("add_7_5", 1'b0, 8'd7, 8'd5, 0);
    chk("add_7_5_lit_res", res4, 4'hC); chk("add_7_5_lit_cout", cout4, 0);
    chk("add_7_5_lit_ovf", ovf4, 1);    chk("add_7_5_lit_zero", zero4, 0);
    run_op("sub_5_7", 1'b1, 8'd5, 8'd7, 0);
    chk("sub_5_7_lit_res", res4, 4'hE); chk("sub_5_7_lit_cout", cout4, 0);
    chk("sub_5_7_lit_ovf", ovf4, 0);
    run_op("sub_8_8", 1'b1, 8'd8, 8'd8, 0);
    chk("sub_8_8_lit_res", res4, 0);    chk("sub_8_8_lit_cout", cout4, 1);
    chk("sub_8_8_lit_zero", zero4, 1);  chk("sub_8_8_lit_ovf", ovf4, 0);
    run_op("add_255_1", 1'b0, 8'd255, 8'd1, 0);
    chk("add_255_1_lit_res", res8, 0);  chk("add_255_1_lit_cout", cout8, 1);
    chk("add_255_1_lit_zero", zero8, 1); chk("add_255_1_lit_ovf", ovf8, 0);
    run_op("add_100_50", 1'b0, 8'd100, 8'd50, 0);
    chk("add_100_50_lit_res", res8, 8'd150); chk("add_100_50_lit_ovf", ovf8, 1);

    // Start pulsed while busy is ignored
    run_op("ign_3_2", 1'b0, 8'd3, 8'd2, 2);
    chk("ign_3_2_lit_res", res4, 4'd5);

    // Reset mid-RUN: abort, no done, outputs cleared
    $display("[TB] op reset_mid_run");
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a_in = 8'd9; b_in = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rmid_busy4", busy4, 0); chk("rmid_res4", res4, 0);
    chk("rmid_cout4", cout4, 0); chk("rmid_ovf4", ovf4, 0);
    chk("rmid_zero4", zero4, 0); chk("rmid_busy8", busy8, 0);
    chk("rmid_res8", res8, 0);   chk("rmid_cout8", cout8, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rmid_nodone4", done4, 0);
      chk("rmid_nodone8", done8, 0);
    end
    prev4 = '0;
    prev8 = '0;

    // Back-to-back on the 4-bit instance: new start in its DONE cycle
    $display("[TB] op back_to_back 2+2 then 6-1");
    model(4, 1'b0, 8'd2, 8'd2, ra, c_a, v_a, z_a);
    model(4, 1'b1, 8'd6, 8'd1, rb, c_b, v_b, z_b);
    model(8, 1'b0, 8'd2, 8'd2, rc, c_c, v_c, z_c);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a_in = 8'd2; b_in = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_done4_a", done4, (i == 4));
    end
    chk("b2b_res4_a", res4, ra[3:0]);
    chk("b2b_res4_a_lit", res4, 4'd4);
    start = 1'b1; mode = 1'b1; a_in = 8'd6; b_in = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy4_b", busy4, 1);
    chk("b2b_done4_b0", done4, 0);
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_done4_b", done4, (j == 4));
      if (j == 3) begin
        chk("b2b_done8", done8, 1);
        chk("b2b_res8", res8, rc);
      end
    end
    chk("b2b_res4_b", res4, rb[3:0]);
    chk("b2b_res4_b_lit", res4, 4'd5);
    chk("b2b_cout4_b", cout4, c_b);
    chk("b2b_ovf4_b", ovf4, v_b);
    chk("b2b_zero4_b", zero4, z_b);
    @(posedge clk);
    @(negedge clk);
    prev4 = rb;
    prev8 = rc;

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      run_op($sformatf("rnd%0d", n), 1'($urandom), 8'($urandom), 8'($urandom),
             (sel == 0) ? 0 : sel + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
